digit_field_draw: RTL and testbench

//  Parametrised seven-segment digit-field renderer for the VGA pixel pipeline; successor to fixed-layout time drawing.

---
 rtl/digit_field_draw.sv | 208 ++++++++++++++++++++
 tb/tb_digit_field_draw.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_field_draw.sv
// rtl/digit_field_draw.sv - seven-segment BCD digit-field renderer for the VGA pixel pipeline
//
// Draws DIGITS seven-segment cells at a fixed origin. Value updates are tear-free:
// new values wait in pending_q and move to active_q only on the rising edge of vs_i.
// Blinking cells (edit cursors) are hidden on alternate blink half-periods.
//
// Ports:
//   clk_i, rst_i            pixel clock, synchronous active-high reset
//   digits_i                BCD values, cell d at [4d+3:4d]
//   digits_valid_i          strobe: capture digits_i into pending
//   edit_mask_i, blink_en_i per-cell blink select, global blink enable
//   x_i, y_i                current pixel coordinate
//   hs_i, vs_i, de_i        syncs / data enable aligned with x_i/y_i
//   color_o                 {r,g,b}, 2 cycles after x_i/y_i
//   hs_o, vs_o, de_o        syncs / de delayed to match color_o
module digit_field_draw #(
    parameter int DIGITS       = 6,
    parameter int PIX_X_W      = 12,
    parameter int PIX_Y_W      = 12,
    parameter int X0           = 64,
    parameter int Y0           = 32,
    parameter int DIG_W        = 24,
    parameter int DIG_H        = 40,
    parameter int GAP          = 8,
    parameter int THICK        = 4,
    parameter int BLINK_FRAMES = 30,
    parameter logic [2:0] BG_COLOR = 3'b000,
    parameter logic [2:0] FG_COLOR = 3'b111
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*DIGITS-1:0]   digits_i,
    input  logic                  digits_valid_i,
    input  logic [DIGITS-1:0]     edit_mask_i,
    input  logic                  blink_en_i,
    input  logic [PIX_X_W-1:0]    x_i,
    input  logic [PIX_Y_W-1:0]    y_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    input  logic                  de_i,
    output logic [2:0]            color_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  de_o
);

    localparam int PITCH = DIG_W + GAP;
    localparam int H2    = DIG_H / 2;
    localparam int LX_W  = $clog2(DIG_W);
    localparam int LY_W  = $clog2(DIG_H);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [LX_W-1:0]  LX_LEFT  = LX_W'(THICK);
    localparam logic [LX_W-1:0]  LX_RIGHT = LX_W'(DIG_W - THICK);
    localparam logic [LY_W-1:0]  LY_A     = LY_W'(THICK);
    localparam logic [LY_W-1:0]  LY_D     = LY_W'(DIG_H - THICK);
    localparam logic [LY_W-1:0]  LY_G_LO  = LY_W'(H2 - THICK / 2);
    localparam logic [LY_W-1:0]  LY_G_HI  = LY_W'(H2 - THICK / 2 + THICK);
    localparam logic [LY_W-1:0]  LY_MID   = LY_W'(H2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    // ---------------- frame-synchronous value and blink state ----------------
    logic                  vs_prev_q;
    logic                  frame_start;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic [4*DIGITS-1:0]   active_q, active_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  phase_q, phase_d;

    assign frame_start = vs_i & ~vs_prev_q;

    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        if (digits_valid_i) begin
            pending_d = digits_i;
        end
        if (frame_start) begin
            // A strobe landing on the frame edge goes straight to the display.
            active_d = digits_valid_i ? digits_i : pending_q;
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // ---------------- stage 1: locate cell and local coordinates ----------------
    logic                  inside_d, inside_q;
    logic [IDX_W-1:0]      idx_d, idx_q;
    logic [LX_W-1:0]       lx_d, lx_q;
    logic [LY_W-1:0]       ly_d, ly_q;
    logic [31:0]           x_ext, y_ext;
    logic                  y_in;

    always_comb begin
        x_ext    = 32'(x_i);
        y_ext    = 32'(y_i);
        y_in     = (y_ext >= 32'(Y0)) && (y_ext < 32'(Y0 + DIG_H));
        inside_d = 1'b0;
        idx_d    = '0;
        lx_d     = '0;
        // Compare against each cell's span rather than dividing; the subtraction
        // only happens inside a matched span so it can never wrap.
        for (int d = 0; d < DIGITS; d++) begin
            if (x_ext >= 32'(X0 + d * PITCH) && x_ext < 32'(X0 + d * PITCH + DIG_W)) begin
                inside_d = y_in;
                idx_d    = IDX_W'(d);
                lx_d     = LX_W'(x_ext - 32'(X0 + d * PITCH));
            end
        end
        ly_d = y_in ? LY_W'(y_ext - 32'(Y0)) : '0;
    end

    // ---------------- stage 2: segment hit test and colour ----------------
    logic [3:0]  digit;
    logic        hidden;
    logic [6:0]  seg_on;   // {a,b,c,d,e,f,g}
    logic [6:0]  seg_hit;
    logic        left, right, top;
    logic        de_s1_q, hs_s1_q, vs_s1_q;
    logic [2:0]  color_d;

    always_comb begin
        digit  = 4'd0;
        hidden = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_q == IDX_W'(d)) begin
                digit  = active_q[4*d +: 4];
                hidden = blink_en_i & edit_mask_i[d] & phase_q;
            end
        end
        case (digit)
            4'd0:    seg_on = 7'b1111110;
            4'd1:    seg_on = 7'b0110000;
            4'd2:    seg_on = 7'b1101101;
            4'd3:    seg_on = 7'b1111001;
            4'd4:    seg_on = 7'b0110011;
            4'd5:    seg_on = 7'b1011011;
            4'd6:    seg_on = 7'b1011111;
            4'd7:    seg_on = 7'b1110000;
            4'd8:    seg_on = 7'b1111111;
            4'd9:    seg_on = 7'b1111011;
            default: seg_on = 7'b0000000;
        endcase
        left    = lx_q < LX_LEFT;
        right   = lx_q >= LX_RIGHT;
        top     = ly_q < LY_MID;
        seg_hit = {ly_q < LY_A,
                   right & top,
                   right & ~top,
                   ly_q >= LY_D,
                   left & ~top,
                   left & top,
                   (ly_q >= LY_G_LO) && (ly_q < LY_G_HI)};
        if (!de_s1_q) begin
            color_d = 3'b000;
        end else if (inside_q && !hidden && |(seg_on & seg_hit)) begin
            color_d = FG_COLOR;
        end else begin
            color_d = BG_COLOR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vs_prev_q <= 1'b0;
            pending_q <= '0;
            active_q  <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            inside_q  <= 1'b0;
            idx_q     <= '0;
            lx_q      <= '0;
            ly_q      <= '0;
            de_s1_q   <= 1'b0;
            hs_s1_q   <= 1'b0;
            vs_s1_q   <= 1'b0;
            color_o   <= 3'b000;
            hs_o      <= 1'b0;
            vs_o      <= 1'b0;
            de_o      <= 1'b0;
        end else begin
            vs_prev_q <= vs_i;
            pending_q <= pending_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            inside_q  <= inside_d;
            idx_q     <= idx_d;
            lx_q      <= lx_d;
            ly_q      <= ly_d;
            de_s1_q   <= de_i;
            hs_s1_q   <= hs_i;
            vs_s1_q   <= vs_i;
            color_o   <= color_d;
            hs_o      <= hs_s1_q;
            vs_o      <= vs_s1_q;
            de_o      <= de_s1_q;
        end
    end

endmodule

// File: tb/tb_digit_field_draw.sv
// tb/tb_digit_field_draw.sv - randomized self-checking bench for digit_field_draw
module tb_digit_field_draw;

    localparam int DIGITS = 6;
    localparam int X0 = 64, Y0 = 32, DIG_W = 24, DIG_H = 40, GAP = 8, THICK = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int H2 = DIG_H / 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [23:0] digits_i = '0;
    logic        digits_valid_i = 1'b0;
    logic [5:0]  edit_mask_i = '0;
    logic        blink_en_i = 1'b0;
    logic [11:0] x_i = '0, y_i = '0;
    logic        hs_i = 1'b0, vs_i = 1'b0, de_i = 1'b0;
    logic [2:0]  color_o;
    logic        hs_o, vs_o, de_o;

    int n_checks = 0;
    int n_pass = 0;

    // reference state, updated only by the bench's own stimulus tasks
    logic [23:0] m_pending, m_active;
    int          m_frames;
    logic        m_phase;

    always #5 clk = ~clk;

    digit_field_draw #(.BLINK_FRAMES(BLINK_FRAMES)) dut (
        .clk_i(clk), .rst_i(rst_i), .digits_i(digits_i), .digits_valid_i(digits_valid_i),
        .edit_mask_i(edit_mask_i), .blink_en_i(blink_en_i), .x_i(x_i), .y_i(y_i),
        .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i),
        .color_o(color_o), .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic string seg_str(input int v);
        case (v)
            0: return "abcdef";
            1: return "bc";
            2: return "abdeg";
            3: return "abcdg";
            4: return "bcfg";
            5: return "acdfg";
            6: return "acdefg";
            7: return "abc";
            8: return "abcdefg";
            9: return "abcdfg";
            default: return "";
        endcase
    endfunction

    function automatic bit seg_covers(input byte c, input int lx, input int ly);
        case (c)
            "a": return ly < THICK;
            "d": return ly >= DIG_H - THICK;
            "g": return ly >= H2 - THICK / 2 && ly < H2 - THICK / 2 + THICK;
            "f": return lx < THICK && ly < H2;
            "b": return lx >= DIG_W - THICK && ly < H2;
            "e": return lx < THICK && ly >= H2;
            "c": return lx >= DIG_W - THICK && ly >= H2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] model_color(input int x, input int y, input logic de);
        int rel, d, lx, ly, v;
        string s;
        if (!de) return 3'b000;
        if (x < X0 || y < Y0) return 3'b000;
        rel = x - X0;
        d   = rel / (DIG_W + GAP);
        lx  = rel % (DIG_W + GAP);
        ly  = y - Y0;
        if (d >= DIGITS || lx >= DIG_W || ly >= DIG_H) return 3'b000;
        if (blink_en_i && edit_mask_i[d] && m_phase) return 3'b000;
        v = int'(m_active[4*d +: 4]);
        s = seg_str(v);
        for (int i = 0; i < s.len(); i++)
            if (seg_covers(s[i], lx, ly)) return 3'b111;
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_pending = '0;
        m_active  = '0;
        m_frames  = 0;
        m_phase   = 1'b0;
    endtask

    task automatic model_frame();
        m_frames++;
        m_phase = ((m_frames / BLINK_FRAMES) % 2) == 1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic load_digits(input logic [23:0] v);
        digits_i = v;
        digits_valid_i = 1'b1;
        tick();
        digits_valid_i = 1'b0;
        m_pending = v;
    endtask

    task automatic new_frame(input bit with_load, input logic [23:0] v);
        vs_i = 1'b1;
        if (with_load) begin
            digits_i = v;
            digits_valid_i = 1'b1;
        end
        tick();
        digits_valid_i = 1'b0;
        if (with_load) m_pending = v;
        m_active = m_pending;
        model_frame();
        tick(); tick();
        vs_i = 1'b0;
        tick(); tick();
    endtask

    task automatic check_pixel(input string tag, input int x, input int y, input logic de);
        x_i = 12'(x);
        y_i = 12'(y);
        de_i = de;
        tick();
        de_i = 1'b0;
        tick();
        check(tag, 32'(color_o), 32'(model_color(x, y, de)));
    endtask

    logic [2:0] hist[$];

    initial begin
        model_reset();
        // 1: reset state and first pixels
        tick(); tick();
        check("reset_out", {28'd0, color_o, hs_o, vs_o, de_o}, 32'd0);
        rst_i = 1'b0;
        check_pixel("seg_a_cell0", 64, 32, 1'b1);
        check("seg_a_const", 32'(color_o), 32'h7);
        check_pixel("g_off_zero", 76, 52, 1'b1);

        // 2: mid-frame update is held until the next vs rise
        load_digits(24'h000008);
        check_pixel("held_value", 76, 52, 1'b1);
        check("held_const", 32'(color_o), 32'h0);
        new_frame(1'b0, '0);
        check_pixel("after_frame", 76, 52, 1'b1);

        // 4: blank code and digit 1
        new_frame(1'b1, 24'h000A00);
        for (int i = 0; i < 20; i++)
            check_pixel("blank_cell2", $urandom_range(128, 151), $urandom_range(32, 71), 1'b1);
        new_frame(1'b1, 24'h000100);
        check_pixel("cell2_seg_b", 150, 40, 1'b1);
        check_pixel("cell2_seg_c", 150, 65, 1'b1);

        // random digits, mask, blink and pixels
        for (int r = 0; r < 6; r++) begin
            edit_mask_i = 6'($urandom);
            blink_en_i  = 1'($urandom);
            if (r % 2 == 0) load_digits(24'($urandom));
            new_frame(r % 3 == 0, 24'($urandom));
            for (int i = 0; i < 60; i++)
                check_pixel("random_px", $urandom_range(40, 300), $urandom_range(20, 90),
                            1'($urandom_range(0, 3) != 0));
        end
        blink_en_i = 1'b0;

        // 5: de gating and sync delay
        new_frame(1'b1, 24'h888888);
        check_pixel("de_low", 64, 32, 1'b0);
        for (int i = 0; i < 40; i++) begin
            hs_i = 1'($urandom); vs_i = 1'($urandom); de_i = 1'($urandom);
            hist.push_back({hs_i, vs_i, de_i});
            tick();
            if (i >= 1) check("sync_delay", {29'd0, hs_o, vs_o, de_o}, {29'd0, hist[i-1]});
        end
        hs_i = 1'b0; vs_i = 1'b0; de_i = 1'b0;
        tick(); tick();

        // 6: reset mid-line after showing 123456
        do_reset();
        load_digits(24'h123456);
        new_frame(1'b0, '0);
        check_pixel("pre_reset", 150, 40, 1'b1);
        x_i = 12'd64; y_i = 12'd32; de_i = 1'b1; hs_i = 1'b1;
        tick();
        rst_i = 1'b1;
        tick();
        check("mid_reset_out", {28'd0, color_o, hs_o, vs_o, de_o}, 32'd0);
        rst_i = 1'b0; hs_i = 1'b0;
        model_reset();
        check_pixel("post_reset_a", 64, 32, 1'b1);
        check_pixel("post_reset_g", 76, 52, 1'b1);

        // 3: blink sequence from counter restart
        edit_mask_i = 6'b000001;
        blink_en_i  = 1'b1;
        for (int f = 0; f < 6; f++) begin
            check_pixel("blink_cell0", 64, 32, 1'b1);
            check("blink_cell0_sched", 32'(color_o), (f == 2 || f == 3) ? 32'h0 : 32'h7);
            check_pixel("blink_cell1", 96, 32, 1'b1);
            new_frame(1'b0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
